// File: rtl/parent_feeder.sv
`default_nettype none
// ============================================================================
// Module   : parent_feeder
// Purpose  : Caregiver controller placed upstream of the kid FSM. Accepts the
//            kid's registered hunger request, spends a cooking delay, issues a
//            one-cycle meal pulse, waits a reading gap, then issues a one-cycle
//            book pulse. Keeps a finite pantry that is restocked on demand
//            when a request arrives with nothing left in stock.
// Ports    : clk          - clock, rising edge
//            resetb       - asynchronous active-low reset
//            request      - hunger request from the kid (registered at source)
//            meal         - one-cycle pulse that feeds the kid
//            book         - one-cycle pulse that sends the kid to study
//            busy         - high whenever the controller is not idle
//            empty        - high when the pantry holds no meals
//            pantry_cnt   - meals remaining in stock
//            meals_served - total meals delivered, saturating at 255
// Revision : 1.0 - initial release
// ============================================================================
module parent_feeder #(
    parameter int COOK_CYCLES    = 3,
    parameter int READ_GAP       = 2,
    parameter int PANTRY_MAX     = 4,
    parameter int RESTOCK_CYCLES = 5
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       request,
    output logic       meal,
    output logic       book,
    output logic       busy,
    output logic       empty,
    output logic [2:0] pantry_cnt,
    output logic [7:0] meals_served
);

    // The shared down-counter must hold the largest load value (N-1) of the
    // three timed states.
    localparam int MAX_AB = (COOK_CYCLES > READ_GAP) ? COOK_CYCLES : READ_GAP;
    localparam int MAX_CYCLES = (MAX_AB > RESTOCK_CYCLES) ? MAX_AB : RESTOCK_CYCLES;
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] COOK_LOAD    = CNT_W'(COOK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(READ_GAP - 1);
    localparam logic [CNT_W-1:0] RESTOCK_LOAD = CNT_W'(RESTOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [2:0]       PANTRY_FULL  = 3'(PANTRY_MAX);
    localparam logic [7:0]       SERVED_SAT   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COOK      = 3'd1,
        ST_SERVE     = 3'd2,
        ST_WAIT_READ = 3'd3,
        ST_READ      = 3'd4,
        ST_RESTOCK   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       pantry_nxt;
    logic [7:0]       served_nxt;

    // ------------------------------------------------------------------------
    // State, counter and bookkeeping registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pantry_cnt   <= PANTRY_FULL;
            meals_served <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            pantry_cnt   <= pantry_nxt;
            meals_served <= served_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. request is only looked at in IDLE: once cooking starts
    // the meal is committed, and the kid's request lingers one cycle after it
    // eats, so listening anywhere else would double-feed.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pantry_nxt = pantry_cnt;
        served_nxt = meals_served;

        case (state)
            ST_IDLE: begin
                if (request) begin
                    if (pantry_cnt != 3'd0) begin
                        state_nxt = ST_COOK;
                        cnt_nxt   = COOK_LOAD;
                    end else begin
                        state_nxt = ST_RESTOCK;
                        cnt_nxt   = RESTOCK_LOAD;
                    end
                end
            end

            ST_COOK: begin
                if (cnt == '0) begin
                    state_nxt = ST_SERVE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            ST_SERVE: begin
                state_nxt = ST_WAIT_READ;
                cnt_nxt   = GAP_LOAD;
                // SERVE is only reachable with stock on hand; the guard keeps
                // the count from ever wrapping regardless.
                if (pantry_cnt != 3'd0) begin
                    pantry_nxt = pantry_cnt - 3'd1;
                end
                if (meals_served != SERVED_SAT) begin
                    served_nxt = meals_served + 8'd1;
                end
            end

            ST_WAIT_READ: begin
                if (cnt == '0) begin
                    state_nxt = ST_READ;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            ST_READ: begin
                state_nxt = ST_IDLE;
            end

            ST_RESTOCK: begin
                // Return to IDLE rather than straight to COOK, so a request
                // still held high is re-accepted through the normal path.
                if (cnt == '0) begin
                    state_nxt  = ST_IDLE;
                    pantry_nxt = PANTRY_FULL;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs decoded purely from registers; no path from request.
    // ------------------------------------------------------------------------
    assign meal  = (state == ST_SERVE);
    assign book  = (state == ST_READ);
    assign busy  = (state != ST_IDLE);
    assign empty = (pantry_cnt == 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_parent_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_parent_feeder
// Purpose  : Directed self-checking bench for parent_feeder with default
//            parameters. A small behavioural kid model can drive request to
//            close the loop; otherwise request is driven directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parent_feeder;

    logic       clk;
    logic       resetb;
    logic       request;
    logic       meal;
    logic       book;
    logic       busy;
    logic       empty;
    logic [2:0] pantry_cnt;
    logic [7:0] meals_served;

    logic       req_drv;
    logic       kid_mode;

    int checks;
    int errors;

    // Behavioural kid: hungry -> full on meal -> study on book -> hungry.
    // Its request is registered, so it stays high one cycle after the meal.
    localparam logic [1:0] K_HUNGRY = 2'd0;
    localparam logic [1:0] K_FULL   = 2'd1;
    localparam logic [1:0] K_STUDY  = 2'd2;

    logic [1:0] kid_state;
    logic       kid_req;
    int         kid_returns;

    assign request = kid_mode ? kid_req : req_drv;

    parent_feeder dut (
        .clk          (clk),
        .resetb       (resetb),
        .request      (request),
        .meal         (meal),
        .book         (book),
        .busy         (busy),
        .empty        (empty),
        .pantry_cnt   (pantry_cnt),
        .meals_served (meals_served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            kid_state   <= K_HUNGRY;
            kid_req     <= 1'b0;
            kid_returns <= 0;
        end else begin
            kid_req <= (kid_state == K_HUNGRY);
            case (kid_state)
                K_HUNGRY: if (meal) kid_state <= K_FULL;
                K_FULL:   if (book) kid_state <= K_STUDY;
                default: begin
                    kid_state   <= K_HUNGRY;
                    kid_returns <= kid_returns + 1;
                end
            endcase
        end
    end

    task automatic do_reset();
        kid_mode = 1'b0;
        req_drv  = 1'b0;
        @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
    endtask

    task automatic test_reset();
        req_drv  = 1'b1;
        kid_mode = 1'b0;
        resetb   = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (meal !== 1'b0) begin errors++; $display("FAIL reset_meal got %b exp 0", meal); end
        checks++; if (book !== 1'b0) begin errors++; $display("FAIL reset_book got %b exp 0", book); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (pantry_cnt !== 3'd4) begin errors++; $display("FAIL reset_pantry got %0d exp 4", pantry_cnt); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty got %b exp 0", empty); end
        checks++; if (meals_served !== 8'd0) begin errors++; $display("FAIL reset_served got %0d exp 0", meals_served); end
        req_drv = 1'b0;
        resetb  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (meal !== 1'b0 || book !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_release cyc %0d got meal=%b book=%b busy=%b exp all 0", k, meal, book, busy);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        req_drv = 1'b1;
        @(posedge clk);                       // accept edge E
        for (int k = 0; k <= 8; k++) begin    // k: state after edge E+k
            @(negedge clk);
            req_drv = 1'b0;
            checks++; if (meal !== (k == 3)) begin errors++; $display("FAIL single_meal k=%0d got %b exp %b", k, meal, (k == 3)); end
            checks++; if (book !== (k == 6)) begin errors++; $display("FAIL single_book k=%0d got %b exp %b", k, book, (k == 6)); end
            checks++; if (busy !== (k <= 6)) begin errors++; $display("FAIL single_busy k=%0d got %b exp %b", k, busy, (k <= 6)); end
        end
        checks++; if (pantry_cnt !== 3'd3) begin errors++; $display("FAIL single_pantry got %0d exp 3", pantry_cnt); end
        checks++; if (meals_served !== 8'd1) begin errors++; $display("FAIL single_served got %0d exp 1", meals_served); end
    endtask

    task automatic test_closed_loop();
        int meals_seen;
        int books_seen;
        bit done;
        meals_seen = 0;
        books_seen = 0;
        done       = 1'b0;
        do_reset();
        kid_mode = 1'b1;
        for (int c = 0; c < 150 && !done; c++) begin
            @(negedge clk);
            if (meal) meals_seen++;
            if (book) books_seen++;
            if (meal && book) begin
                checks++; errors++;
                $display("FAIL loop_exclusive cyc %0d got meal=1 book=1 exp not both", c);
            end
            if (books_seen == 4) done = 1'b1;
        end
        kid_mode = 1'b0;
        req_drv  = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL loop_timeout got books=%0d exp 4", books_seen); end
        repeat (3) begin
            @(negedge clk);
            if (meal) meals_seen++;
        end
        checks++; if (meals_seen !== 4) begin errors++; $display("FAIL loop_meals got %0d exp 4", meals_seen); end
        checks++; if (books_seen !== 4) begin errors++; $display("FAIL loop_books got %0d exp 4", books_seen); end
        checks++; if (kid_returns !== 4) begin errors++; $display("FAIL loop_kid_hungry got %0d exp 4", kid_returns); end
        checks++; if (pantry_cnt !== 3'd0) begin errors++; $display("FAIL loop_pantry got %0d exp 0", pantry_cnt); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL loop_empty got %b exp 1", empty); end
        checks++; if (meals_served !== 8'd4) begin errors++; $display("FAIL loop_served got %0d exp 4", meals_served); end
    endtask

    // Runs straight after the closed loop, with the pantry empty.
    task automatic test_exhaustion();
        @(negedge clk);
        req_drv = 1'b1;
        @(posedge clk);                       // accept edge A -> RESTOCK
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            checks++; if (meal !== (k == 9)) begin errors++; $display("FAIL exh_meal k=%0d got %b exp %b", k, meal, (k == 9)); end
            if (k <= 4) begin
                checks++; if (pantry_cnt !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL exh_restock k=%0d got pantry=%0d busy=%b exp 0/1", k, pantry_cnt, busy); end
            end
            if (k == 5) begin
                checks++; if (pantry_cnt !== 3'd4 || busy !== 1'b0) begin errors++; $display("FAIL exh_refill got pantry=%0d busy=%b exp 4/0", pantry_cnt, busy); end
            end
            if (k == 10) begin
                checks++; if (pantry_cnt !== 3'd3) begin errors++; $display("FAIL exh_after_serve got %0d exp 3", pantry_cnt); end
            end
            if (k == 9) req_drv = 1'b0;
        end
    endtask

    task automatic test_reset_mid_cook();
        do_reset();
        @(negedge clk);
        req_drv = 1'b1;
        @(posedge clk);                       // accept edge
        @(negedge clk);
        req_drv = 1'b0;
        @(negedge clk);
        resetb = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (pantry_cnt !== 3'd4) begin errors++; $display("FAIL midrst_pantry got %0d exp 4", pantry_cnt); end
        checks++; if (meals_served !== 8'd0) begin errors++; $display("FAIL midrst_served got %0d exp 0", meals_served); end
        @(negedge clk);
        resetb = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (meal !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_after cyc %0d got meal=%b busy=%b exp 0/0", k, meal, busy);
            end
        end
    endtask

    task automatic test_saturation();
        int n;
        int exp_served;
        n = 0;
        do_reset();
        req_drv = 1'b1;
        for (int c = 0; c < 6000 && n < 260; c++) begin
            @(negedge clk);
            if (pantry_cnt > 3'd4) begin
                checks++; errors++;
                $display("FAIL sat_underflow cyc %0d got %0d exp <=4", c, pantry_cnt);
            end
            if (meal) begin
                exp_served = (n > 255) ? 255 : n;
                checks++; if (pantry_cnt !== 3'(4 - (n % 4))) begin errors++; $display("FAIL sat_pantry meal %0d got %0d exp %0d", n, pantry_cnt, 4 - (n % 4)); end
                checks++; if (meals_served !== 8'(exp_served)) begin errors++; $display("FAIL sat_served meal %0d got %0d exp %0d", n, meals_served, exp_served); end
                n++;
            end
        end
        req_drv = 1'b0;
        checks++; if (n != 260) begin errors++; $display("FAIL sat_timeout got %0d meals exp 260", n); end
        repeat (12) @(negedge clk);
        checks++; if (meals_served !== 8'd255) begin errors++; $display("FAIL sat_final got %0d exp 255", meals_served); end
        checks++; if (pantry_cnt !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL sat_pantry_end got %0d/%b exp 0/1", pantry_cnt, empty); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        resetb   = 1'b0;
        req_drv  = 1'b0;
        kid_mode = 1'b0;
        test_reset();
        test_single();
        test_closed_loop();
        test_exhaustion();
        test_reset_mid_cook();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parent_feeder.md
Name: parent_feeder

Overview:
- Caregiver controller that sits directly upstream of the kid FSM. It consumes the kid's registered `request` (hunger) output and produces the `meal` and `book` single-cycle pulses that drive the kid through hungry, full, study and back to hungry.
- Models cooking latency, a finite pantry with restocking, and a reading gap after each meal.
- Provides status outputs for the top level.

Parameters:
- COOK_CYCLES, 3, cycles spent in COOK after a request is accepted; legal range >= 1.
- READ_GAP, 2, cycles spent in WAIT_READ between the meal pulse and the book pulse; legal range >= 1.
- PANTRY_MAX, 4, meals in stock after reset or restock; legal range 1..7.
- RESTOCK_CYCLES, 5, cycles spent in RESTOCK; legal range >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetb  in  1  reset: asynchronous, active-low.
- request  in  1  hunger request from the kid (registered at the source).
- meal  out  1  one-cycle pulse that feeds the kid.
- book  out  1  one-cycle pulse that sends the kid to study.
- busy  out  1  high whenever the FSM is not in IDLE.
- empty  out  1  high when pantry_cnt == 0.
- pantry_cnt  out  3  meals remaining in stock.
- meals_served  out  8  total meals delivered; saturates at 255.

Behaviour:
- All outputs come from flops or are decoded from the state register. No combinational path from request to any output.
- Reset (async, resetb = 0):
  - state = IDLE, internal counter = 0.
  - meal = 0, book = 0, busy = 0.
  - pantry_cnt = PANTRY_MAX, empty = 0, meals_served = 0.
- Reset mid-operation aborts immediately. No meal or book pulse follows reset release, and pantry_cnt is reloaded to PANTRY_MAX.
- States:
  - IDLE, COOK, SERVE, WAIT_READ, READ, RESTOCK.
  - State encoding is 3 bits.
  - One down-counter, sized for the largest parameter, is shared by COOK, WAIT_READ and RESTOCK.
- IDLE: request is sampled on each edge.
  - request = 1 and pantry_cnt > 0: go to COOK and load the counter with COOK_CYCLES-1.
  - request = 1 and pantry_cnt == 0: go to RESTOCK and load the counter with RESTOCK_CYCLES-1.
  - Otherwise stay in IDLE.
- COOK:
  - Decrement the counter; when it is 0, go to SERVE.
  - request is ignored. Cooking is committed, so the meal is delivered even if request drops.
- SERVE: lasts exactly one cycle, and meal = 1 for that cycle.
  - On the exit edge: pantry_cnt decrements by 1, meals_served increments unless it is already 255, and the counter loads READ_GAP-1.
  - Next state is WAIT_READ.
- WAIT_READ:
  - Decrement the counter; when it is 0, go to READ.
  - request is ignored. The kid's registered request stays high for one cycle after it consumes the meal, and that stale value must not trigger a second meal.
- READ: lasts exactly one cycle, and book = 1 for that cycle. Next state is IDLE.
- RESTOCK:
  - Decrement the counter; when it is 0, load pantry_cnt = PANTRY_MAX and go to IDLE.
  - If request is still high, it is accepted in IDLE on the following edge.
  - No meal is issued while in RESTOCK.
- Latency:
  - meal rises COOK_CYCLES edges after the edge at which IDLE samples request = 1.
  - book rises READ_GAP+1 edges after meal rises.
  - Defaults: meal at +3, book at +6 relative to the accept edge.
- Exclusivity:
  - meal and book are never high in the same cycle.
  - At most one meal is issued per accepted request.
- Pantry boundary: the last meal takes pantry_cnt from 1 to 0 and empty rises on that same edge. The next request goes through RESTOCK before COOK.
- Counters never wrap: pantry_cnt never underflows and meals_served holds at 255.

Test Plan:
- Reset values: hold resetb = 0 with request = 1.
  - Required: meal = 0, book = 0, busy = 0, pantry_cnt = 4, empty = 0, meals_served = 0.
  - Release reset: no pulse until request has been sampled in IDLE.
- Single transaction (defaults): assert request, accepted at edge E.
  - Required: meal high only in cycle E+3..E+4, book high only in cycle E+6..E+7, then busy = 0.
  - Required afterwards: pantry_cnt = 3, meals_served = 1.
- Closed loop with the kid FSM instantiated for 4 transactions.
  - Required: exactly 4 meal and 4 book pulses, and the kid returns to hungry each time.
  - Required: the stale request high in the cycle after meal never produces an extra meal.
  - Required at the end: pantry_cnt = 0, empty = 1.
- Pantry exhaustion: issue a 5th request with pantry_cnt = 0.
  - Required: 5 RESTOCK cycles with no meal, then pantry_cnt = 4.
  - Required: meal rises 1+5+3 = 9 edges after the accept edge, and pantry_cnt = 3 after SERVE.
- Reset mid-COOK: assert resetb = 0 one cycle after accept.
  - Required: no meal pulse, pantry_cnt = 4, meals_served unchanged at 0, state IDLE.
- Saturation: run 260 transactions.
  - Required: meals_served = 255 and holds.
  - Required: pantry_cnt cycles 4 to 0 with a restock each time, and never underflows.
